// File: rtl/gps_pkg.sv
// Shared constants and state encoding for the pcode sequencing logic.
// Both the controller and its bench pull satellite width and epoch length from here.
package gps_pkg;

   localparam int SAT_WIDTH   = 6;
   localparam int EPOCH_CHIPS = 15345000;
   localparam int CHIP_W      = 24;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE   = 2'd0;
   localparam state_t ST_LOAD   = 2'd1;
   localparam state_t ST_SETTLE = 2'd2;
   localparam state_t ST_RUN    = 2'd3;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at index ptr and wraps,
// returning a one-hot grant and the winner's index.
module rr_arbiter #(
   parameter int NREQ = 4
) (
   input  logic [NREQ-1:0]         req,
   input  logic [$clog2(NREQ)-1:0] ptr,
   output logic [NREQ-1:0]         gnt,
   output logic [$clog2(NREQ)-1:0] idx
);

   localparam int IW = $clog2(NREQ);

   // cand[k] is the channel examined at search position k, i.e. (ptr + k) mod NREQ.
   logic [IW-1:0] cand [NREQ];

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : gen_cand
         logic [IW:0] sum;
         assign sum      = {1'b0, ptr} + (IW+1)'(gi);
         assign cand[gi] = (sum >= (IW+1)'(NREQ)) ? IW'(sum - (IW+1)'(NREQ)) : IW'(sum);
      end
   endgenerate

   always_comb begin
      logic found;
      found = 1'b0;
      gnt   = '0;
      idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!found && req[cand[k]]) begin
            found         = 1'b1;
            idx           = cand[k];
            gnt[cand[k]]  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pcode_ctrl.sv
// Sequencer in front of one pcode generator: arbitrates channel requests, reloads
// the generator, waits a settle window, then paces chip enables and counts epochs.
module pcode_ctrl #(
   parameter int NREQ        = 4,
   parameter int SAT_WIDTH   = gps_pkg::SAT_WIDTH,
   parameter int DIV_WIDTH   = 16,
   parameter int SETTLE      = 4,
   parameter int EPOCH_CHIPS = gps_pkg::EPOCH_CHIPS
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NREQ-1:0]           req,
   input  logic [NREQ*SAT_WIDTH-1:0] req_sat,
   output logic [NREQ-1:0]           gnt,
   input  logic                      run,
   input  logic [DIV_WIDTH-1:0]      div,
   output logic [SAT_WIDTH-1:0]      pcode_sat,
   output logic                      pcode_prn_changed,
   output logic                      pcode_en,
   output logic [$clog2(NREQ)-1:0]   owner,
   output logic                      busy,
   output logic [23:0]               chip_cnt,
   output logic                      epoch
);

   import gps_pkg::state_t;
   import gps_pkg::ST_IDLE;
   import gps_pkg::ST_LOAD;
   import gps_pkg::ST_SETTLE;
   import gps_pkg::ST_RUN;
   import gps_pkg::CHIP_W;

   localparam int IW = $clog2(NREQ);
   localparam int SW = $clog2(SETTLE + 1);

   state_t                 state_reg, state_next;
   logic [IW-1:0]          ptr_reg;
   logic [SW-1:0]          settle_reg;
   logic [DIV_WIDTH-1:0]   div_reg;
   logic [NREQ-1:0]        gnt_reg;
   logic [SAT_WIDTH-1:0]   sat_reg;
   logic                   prn_changed_reg;
   logic                   en_reg;
   logic [IW-1:0]          owner_reg;
   logic                   busy_reg;
   logic [CHIP_W-1:0]      chip_reg;
   logic                   epoch_reg;

   logic [NREQ-1:0]        arb_gnt;
   logic [IW-1:0]          arb_idx;
   logic [SAT_WIDTH-1:0]   win_sat;
   logic                   en_fire;
   logic                   grant;

   rr_arbiter #(
      .NREQ (NREQ)
   ) u_arb (
      .req (req),
      .ptr (ptr_reg),
      .gnt (arb_gnt),
      .idx (arb_idx)
   );

   // A chip enable always wins over a pending request, so the current chip is
   // only abandoned on a cycle that would not have produced an enable anyway.
   always_comb begin
      en_fire = (state_reg == ST_RUN) && run && (div_reg == '0);
      grant   = (|req) && ((state_reg == ST_IDLE) || ((state_reg == ST_RUN) && !en_fire));
      win_sat = req_sat[arb_idx*SAT_WIDTH +: SAT_WIDTH];
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:   if (grant) state_next = ST_LOAD;
         ST_LOAD:   state_next = (sat_reg == '0) ? ST_IDLE : ST_SETTLE;
         ST_SETTLE: if (settle_reg == '0) state_next = ST_RUN;
         ST_RUN:    if (grant) state_next = ST_LOAD;
         default:   state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= ST_IDLE;
         ptr_reg         <= '0;
         settle_reg      <= '0;
         div_reg         <= '0;
         gnt_reg         <= '0;
         sat_reg         <= '0;
         prn_changed_reg <= 1'b0;
         en_reg          <= 1'b0;
         owner_reg       <= '0;
         busy_reg        <= 1'b0;
         chip_reg        <= '0;
         epoch_reg       <= 1'b0;
      end else begin
         state_reg       <= state_next;
         busy_reg        <= (state_next == ST_LOAD) || (state_next == ST_SETTLE);
         gnt_reg         <= '0;
         prn_changed_reg <= 1'b0;
         en_reg          <= 1'b0;
         epoch_reg       <= 1'b0;

         if (grant) begin
            gnt_reg         <= arb_gnt;
            owner_reg       <= arb_idx;
            ptr_reg         <= (arb_idx == IW'(NREQ-1)) ? '0 : arb_idx + 1'b1;
            sat_reg         <= win_sat;
            prn_changed_reg <= 1'b1;
            chip_reg        <= '0;
         end

         if (state_reg == ST_LOAD)
            settle_reg <= SW'(SETTLE - 1);

         if (state_reg == ST_SETTLE) begin
            if (settle_reg == '0)
               div_reg <= div;
            else
               settle_reg <= settle_reg - 1'b1;
         end

         if (en_fire) begin
            en_reg  <= 1'b1;
            div_reg <= div;
            if (chip_reg == CHIP_W'(EPOCH_CHIPS - 1)) begin
               chip_reg  <= '0;
               epoch_reg <= 1'b1;
            end else begin
               chip_reg  <= chip_reg + 1'b1;
            end
         end else if ((state_reg == ST_RUN) && !grant && run) begin
            div_reg <= div_reg - 1'b1;
         end
      end
   end

   assign gnt               = gnt_reg;
   assign pcode_sat         = sat_reg;
   assign pcode_prn_changed = prn_changed_reg;
   assign pcode_en          = en_reg;
   assign owner             = owner_reg;
   assign busy              = busy_reg;
   assign chip_cnt          = chip_reg;
   assign epoch             = epoch_reg;

endmodule

// File: tb/tb_pcode_ctrl.sv
// Directed bench for pcode_ctrl: grant sequencing, settle window, chip pacing,
// run gating, epoch wrap, zero-sat reload and mid-run reset.
module tb_pcode_ctrl;

   localparam int NREQ = 4;
   localparam int SATW = 6;
   localparam int DIVW = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req;
   logic [NREQ*SATW-1:0] req_sat;
   logic [NREQ-1:0]   gnt;
   logic              run;
   logic [DIVW-1:0]   div;
   logic [SATW-1:0]   pcode_sat;
   logic              pcode_prn_changed;
   logic              pcode_en;
   logic [1:0]        owner;
   logic              busy;
   logic [23:0]       chip_cnt;
   logic              epoch;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pcode_ctrl #(
      .NREQ        (NREQ),
      .SAT_WIDTH   (SATW),
      .DIV_WIDTH   (DIVW),
      .SETTLE      (4),
      .EPOCH_CHIPS (8)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .req               (req),
      .req_sat           (req_sat),
      .gnt               (gnt),
      .run               (run),
      .div               (div),
      .pcode_sat         (pcode_sat),
      .pcode_prn_changed (pcode_prn_changed),
      .pcode_en          (pcode_en),
      .owner             (owner),
      .busy              (busy),
      .chip_cnt          (chip_cnt),
      .epoch             (epoch)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end else begin
         $display("ok   %s = %0d", tag, obs);
      end
   endtask

   task automatic set_sat(input int ch, input logic [SATW-1:0] val);
      req_sat[ch*SATW +: SATW] = val;
   endtask

   // Counts samples until pcode_en is seen, giving up after maxc.
   task automatic wait_en(input int maxc, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!pcode_en && n < maxc);
      if (!pcode_en) chk("en_timeout", pcode_en, 1);
   endtask

   // SETTLE-phase samples: no grant, no enable, no reload strobe, busy held.
   task automatic quiet(input int ncyc, input string tag);
      logic bad;
      bad = 1'b0;
      repeat (ncyc) begin
         @(negedge clk);
         bad |= (gnt != '0) | pcode_en | pcode_prn_changed | !busy;
      end
      chk(tag, bad, 0);
   endtask

   task automatic chk_reset_state(input string pfx);
      chk({pfx, "_gnt"},   gnt, 0);
      chk({pfx, "_sat"},   pcode_sat, 0);
      chk({pfx, "_prn"},   pcode_prn_changed, 0);
      chk({pfx, "_en"},    pcode_en, 0);
      chk({pfx, "_owner"}, owner, 0);
      chk({pfx, "_busy"},  busy, 0);
      chk({pfx, "_chip"},  chip_cnt, 0);
      chk({pfx, "_epoch"}, epoch, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   n;
      int   exp_chip;
      logic early;
      logic idle_bad;

      rst = 1'b1; req = '0; req_sat = '0; run = 1'b0; div = 16'd3;
      repeat (3) @(negedge clk);
      chk_reset_state("rst");
      rst = 1'b0;
      @(negedge clk);
      chk("idle_busy", busy, 0);

      // channel 2, sat 5: LOAD next cycle, 4 settle cycles, then RUN
      set_sat(2, 5); req = 4'b0100; run = 1'b1;
      @(negedge clk);
      chk("load_gnt",   gnt, 4'b0100);
      chk("load_prn",   pcode_prn_changed, 1);
      chk("load_sat",   pcode_sat, 5);
      chk("load_owner", owner, 2);
      chk("load_busy",  busy, 1);
      chk("load_chip",  chip_cnt, 0);
      req = '0;
      quiet(4, "settle1");
      @(negedge clk);
      chk("run_busy", busy, 0);
      chk("run_en0",  pcode_en, 0);

      wait_en(20, n); chk("first_en",  n, 4); chk("chip_a", chip_cnt, 1);
      wait_en(20, n); chk("en_period", n, 4); chk("chip_b", chip_cnt, 2);
      div = 16'd7;
      wait_en(20, n); chk("div_deferred", n, 4); chk("chip_c", chip_cnt, 3);
      wait_en(20, n); chk("div7_period",  n, 8); chk("chip_d", chip_cnt, 4);

      // run low for 10 cycles mid-count stretches the gap from 8 to 18
      early = 1'b0;
      repeat (3) begin @(negedge clk); early |= pcode_en; end
      run = 1'b0;
      repeat (10) begin @(negedge clk); early |= pcode_en; end
      run = 1'b1;
      wait_en(30, n);
      chk("run_hold_noen", early, 0);
      chk("run_gap", 13 + n, 18);
      chk("chip_e", chip_cnt, 5);

      // div=0: enable on every cycle, epoch on the wrap 7 -> 0
      div = 16'd0;
      wait_en(20, n); chk("div0_reload", n, 8); chk("chip_f", chip_cnt, 6);
      exp_chip = 6;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         exp_chip = (exp_chip + 1) % 8;
         chk("div0_en", pcode_en, 1);
         chk("chip_seq", chip_cnt, exp_chip);
         chk("epoch", epoch, (exp_chip == 0) ? 1 : 0);
      end

      // request during an enable cycle is deferred to the next non-enable cycle
      div = 16'd3; set_sat(1, 7); req = 4'b0010;
      @(negedge clk);
      chk("defer_en",  pcode_en, 1);
      chk("defer_gnt", gnt, 0);
      @(negedge clk);
      chk("run_gnt",   gnt, 4'b0010);
      chk("run_prn",   pcode_prn_changed, 1);
      chk("run_en0b",  pcode_en, 0);
      chk("run_chip0", chip_cnt, 0);
      chk("run_owner", owner, 1);
      chk("run_sat",   pcode_sat, 7);
      req = '0;

      // request raised during SETTLE is held until RUN
      @(negedge clk);
      set_sat(3, 11); req = 4'b1000;
      quiet(3, "settle_req_held");
      @(negedge clk);
      chk("settle_req_runentry", gnt, 0);
      @(negedge clk);
      chk("held_gnt",   gnt, 4'b1000);
      chk("held_sat",   pcode_sat, 11);
      chk("held_owner", owner, 3);
      req = '0;

      // sat 0 reloads, then falls back to IDLE with no enables
      set_sat(0, 0); req = 4'b0001;
      quiet(4, "settle2");
      @(negedge clk);
      @(negedge clk);
      chk("sat0_gnt", gnt, 4'b0001);
      chk("sat0_prn", pcode_prn_changed, 1);
      chk("sat0_sat", pcode_sat, 0);
      chk("sat0_owner", owner, 0);
      req = '0;
      @(negedge clk);
      chk("sat0_idle_busy", busy, 0);
      idle_bad = 1'b0;
      repeat (6) begin @(negedge clk); idle_bad |= pcode_en; end
      chk("sat0_idle_noen", idle_bad, 0);

      // owner=0: ch3 wins over ch0, ch0 follows after the next settle
      set_sat(0, 13); set_sat(3, 21); req = 4'b1001;
      @(negedge clk);
      chk("rr_first_gnt", gnt, 4'b1000);
      chk("rr_first_sat", pcode_sat, 21);
      req = 4'b0001;
      quiet(4, "settle3");
      @(negedge clk);
      @(negedge clk);
      chk("rr_second_gnt", gnt, 4'b0001);
      chk("rr_second_sat", pcode_sat, 13);
      chk("rr_second_owner", owner, 0);

      // ch1 asks for the sat already loaded: still reloaded
      set_sat(1, 13); req = 4'b0010;
      quiet(4, "settle4");
      @(negedge clk);
      @(negedge clk);
      chk("same_sat_gnt", gnt, 4'b0010);
      chk("same_sat_prn", pcode_prn_changed, 1);
      chk("same_sat_sat", pcode_sat, 13);
      req = '0;

      // reset while running clears everything, including the rr pointer
      quiet(4, "settle5");
      @(negedge clk);
      wait_en(20, n);
      chk("pre_rst_en", pcode_en, 1);
      rst = 1'b1;
      @(negedge clk);
      chk_reset_state("midrst");
      rst = 1'b0;
      set_sat(1, 3); set_sat(3, 4); req = 4'b1010;
      @(negedge clk);
      chk("ptr_reset_gnt", gnt, 4'b0010);
      chk("ptr_reset_owner", owner, 1);
      req = '0;
      repeat (2) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
